// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   - operation encodings (funct[1:0] of MULT/MULTU/DIV/DIVU)
//   - sequencer state enum
//   - iteration count and fixed latencies (acceptance edge to done)
//   - small helpers that decode the operation
package mdu_pkg;

  localparam int MDU_ITERS        = 32;
  localparam int MDU_CNT_W        = $clog2(MDU_ITERS);
  localparam int MDU_LAT_UNSIGNED = 32;
  localparam int MDU_LAT_SIGNED   = 36;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_A  = 3'd1,
    ST_ABS_B  = 3'd2,
    ST_ITER   = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5,
    ST_DONE   = 3'd6
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  // MULT and DIV (funct[0]==0) are the signed variants.
  function automatic logic op_is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_adder_mux.sv
// mdu_adder_mux: selects the operands of the shared external adder from the
// sequencer state. Purely combinational; drives zero whenever no adder
// result is consumed so the shared adder sees quiet inputs.
// Ports:
//   state      current sequencer state
//   is_div     latched operation is DIV/DIVU
//   hi, lo, m  HI, LO and operand register M
//   fix_lo_en  LO needs two's-complement negation in FIX_LO
//   fix_hi_en  HI needs negation in FIX_HI
//   fix_carry  carry saved from the LO negation (multiply only)
//   add_a/b/c  adder operand A, operand B, carry-in
module mdu_adder_mux
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mdu_state_e        state,
  input  logic              is_div,
  input  logic [XLEN-1:0]   hi,
  input  logic [XLEN-1:0]   lo,
  input  logic [XLEN-1:0]   m,
  input  logic              fix_lo_en,
  input  logic              fix_hi_en,
  input  logic              fix_carry,
  output logic [XLEN-1:0]   add_a,
  output logic [XLEN-1:0]   add_b,
  output logic              add_c
);

  always_comb begin
    add_a = '0;
    add_b = '0;
    add_c = 1'b0;
    case (state)
      // LO still holds the raw dividend/multiplicand here, so its MSB is A's sign.
      ST_ABS_A: begin
        if (lo[XLEN-1]) begin
          add_a = ~lo;
          add_c = 1'b1;
        end
      end
      ST_ABS_B: begin
        if (m[XLEN-1]) begin
          add_a = ~m;
          add_c = 1'b1;
        end
      end
      ST_ITER: begin
        if (is_div) begin
          // Trial subtract of M from the partial remainder shifted left by one.
          add_a = {hi[XLEN-2:0], lo[XLEN-1]};
          add_b = ~m;
          add_c = 1'b1;
        end else if (lo[0]) begin
          add_a = hi;
          add_b = m;
        end
      end
      ST_FIX_LO: begin
        if (fix_lo_en) begin
          add_a = ~lo;
          add_c = 1'b1;
        end
      end
      ST_FIX_HI: begin
        if (fix_hi_en) begin
          // 64-bit product negation carries from LO into HI; the remainder
          // is negated on its own.
          add_a = ~hi;
          add_c = is_div ? 1'b1 : fix_carry;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: multi-cycle MIPS32 MULT/MULTU/DIV/DIVU unit that reuses
// one external 32-bit adder, one adder pass per cycle (shift-add multiply,
// restoring divide). Results are held in the HI/LO registers.
// Ports:
//   clk_in, rst_in       clock (rising edge), async active-high reset
//   start_in, op_in      start request and operation (funct[1:0])
//   A_in, B_in           operands, sampled on the acceptance edge
//   busy_out, done_out   busy in all working states; done is a one-cycle pulse
//   div0_out             last accepted op was a divide by zero
//   HI_out, LO_out       architectural HI/LO
//   add_A/B/C_out        shared adder operands and carry-in
//   add_S_in, add_C_in   shared adder sum and carry-out
//   state_dbg_out        current sequencer state
//
// Handshake: start_in is accepted on a rising edge only while the unit is in
// IDLE or DONE; A_in/B_in/op_in are sampled on that same edge. While busy_out
// is high start_in is ignored entirely. done_out is high for exactly the one
// DONE cycle; holding start_in through DONE re-accepts on the DONE edge with
// no IDLE cycle in between. Latency is fixed: 32 cycles unsigned, 36 signed.
module mul_div_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [1:0]        op_in,
  input  logic [XLEN-1:0]   A_in,
  input  logic [XLEN-1:0]   B_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              div0_out,
  output logic [XLEN-1:0]   HI_out,
  output logic [XLEN-1:0]   LO_out,
  output logic [XLEN-1:0]   add_A_out,
  output logic [XLEN-1:0]   add_B_out,
  output logic              add_C_out,
  input  logic [XLEN-1:0]   add_S_in,
  input  logic              add_C_in,
  output mdu_state_e        state_dbg_out
);

  mdu_state_e           state, state_nxt;
  mdu_op_e              op_q;
  logic [XLEN-1:0]      hi_q, lo_q, m_q;
  logic                 s_a_q, s_b_q, fix_carry_q, div0_q;
  logic [MDU_CNT_W-1:0] cnt_q;

  logic       accept;
  logic       is_div, is_signed;
  logic       iter_last;
  logic       fix_lo_en, fix_hi_en;
  logic       div_t, div_take;
  mdu_state_e start_state;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);
  assign iter_last = (cnt_q == MDU_CNT_W'(MDU_ITERS - 1));

  // Quotient takes the sign of A^B; remainder takes the dividend's sign.
  assign fix_lo_en = s_a_q ^ s_b_q;
  assign fix_hi_en = is_div ? s_a_q : (s_a_q ^ s_b_q);

  // Restoring-divide decision: subtract when the shifted-out bit is set
  // (partial remainder >= 2^32 > M) or the trial subtract did not borrow.
  assign div_t    = hi_q[XLEN-1];
  assign div_take = div_t | add_C_in;

  assign start_state = op_is_signed(mdu_op_e'(op_in)) ? ST_ABS_A : ST_ITER;

  // ---------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    accept    = start_in && ((state == ST_IDLE) || (state == ST_DONE));
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = start_state;
      ST_ABS_A:  state_nxt = ST_ABS_B;
      ST_ABS_B:  state_nxt = ST_ITER;
      ST_ITER:   if (iter_last) state_nxt = is_signed ? ST_FIX_LO : ST_DONE;
      ST_FIX_LO: state_nxt = ST_FIX_HI;
      ST_FIX_HI: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = accept ? start_state : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      op_q        <= MDU_MULT;
      hi_q        <= '0;
      lo_q        <= '0;
      m_q         <= '0;
      s_a_q       <= 1'b0;
      s_b_q       <= 1'b0;
      fix_carry_q <= 1'b0;
      div0_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op_q        <= mdu_op_e'(op_in);
            hi_q        <= '0;
            lo_q        <= A_in;
            m_q         <= B_in;
            s_a_q       <= 1'b0;
            s_b_q       <= 1'b0;
            fix_carry_q <= 1'b0;
            div0_q      <= op_in[1] && (B_in == '0);
            cnt_q       <= '0;
          end
        end
        ST_ABS_A: begin
          s_a_q <= lo_q[XLEN-1];
          if (lo_q[XLEN-1]) lo_q <= add_S_in;
        end
        ST_ABS_B: begin
          s_b_q <= m_q[XLEN-1];
          if (m_q[XLEN-1]) m_q <= add_S_in;
        end
        ST_ITER: begin
          cnt_q <= cnt_q + MDU_CNT_W'(1);
          if (is_div) begin
            hi_q <= div_take ? add_S_in : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_q <= {lo_q[XLEN-2:0], div_take};
          end else if (lo_q[0]) begin
            hi_q <= {add_C_in, add_S_in[XLEN-1:1]};
            lo_q <= {add_S_in[0], lo_q[XLEN-1:1]};
          end else begin
            hi_q <= {1'b0, hi_q[XLEN-1:1]};
            lo_q <= {hi_q[0], lo_q[XLEN-1:1]};
          end
        end
        ST_FIX_LO: begin
          if (fix_lo_en) begin
            lo_q <= add_S_in;
            if (!is_div) fix_carry_q <= add_C_in;
          end
        end
        ST_FIX_HI: begin
          if (fix_hi_en) hi_q <= add_S_in;
        end
        default: ;
      endcase
    end
  end

  mdu_adder_mux #(
    .XLEN (XLEN)
  ) u_adder_mux (
    .state     (state),
    .is_div    (is_div),
    .hi        (hi_q),
    .lo        (lo_q),
    .m         (m_q),
    .fix_lo_en (fix_lo_en),
    .fix_hi_en (fix_hi_en),
    .fix_carry (fix_carry_q),
    .add_a     (add_A_out),
    .add_b     (add_B_out),
    .add_c     (add_C_out)
  );

  assign busy_out      = (state != ST_IDLE) && (state != ST_DONE);
  assign done_out      = (state == ST_DONE);
  assign div0_out      = div0_q;
  assign HI_out        = hi_q;
  assign LO_out        = lo_q;
  assign state_dbg_out = state;

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
Multi-cycle controller that executes MIPS32 MULT/MULTU/DIV/DIVU by sequencing one shared external 32-bit adder.
- Shift-add multiply and restoring divide, one adder pass per cycle.
- Results land in architectural HI/LO registers held inside the block.
- Sits beside the ALU in EX. The pipeline stalls on busy_out and reads HI_out/LO_out for MFHI/MFLO.

Parameters:
XLEN, 32, operand width; only 32 is supported, and the iteration count equals XLEN.

Ports:
clk_in  input  1  single clock, rising edge
rst_in  input  1  reset, asynchronous, active-high
start_in  input  1  start request; accepted only in IDLE or DONE
op_in  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU (funct[1:0])
A_in  input  32  multiplicand / dividend, sampled on the acceptance edge
B_in  input  32  multiplier / divisor, sampled on the acceptance edge
busy_out  output  1  high in every state except IDLE and DONE
done_out  output  1  one-cycle pulse in DONE
div0_out  output  1  last accepted op was DIV/DIVU with B_in==0; held until next acceptance
HI_out  output  32  HI register
LO_out  output  32  LO register
add_A_out  output  32  shared adder operand A (combinational from state)
add_B_out  output  32  shared adder operand B
add_C_out  output  1  shared adder carry-in
add_S_in  input  32  shared adder sum
add_C_in  input  1  shared adder carry-out

Behaviour:
- Async reset:
  - State goes to IDLE.
  - HI, LO, operand register M, sign flags, counter and div0 are all cleared.
  - busy and done go low.
  - Adder outputs are driven to 0.
- States: IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI, DONE.
- Acceptance edge E0 (start_in=1 in IDLE or DONE):
  - Latch A, B, op and div0.
  - Set HI=0, LO=A, M=B, cnt=0.
  - Signed op: next state is ABS_A. Unsigned op: next state is ITER.
- ABS_A (1 cycle):
  - If A[31]: adder computes ~LO+1 (B=0, C=1) and LO<=sum.
  - Record sA=A[31].
- ABS_B (1 cycle):
  - Same negation for M if B[31].
  - Record sB=B[31].
- ITER, multiply (32 cycles):
  - If LO[0]: adder computes HI+M (C=0), then {HI,LO}<={carry,sum,LO[31:1]}.
  - Otherwise: {HI,LO}<={0,HI,LO[31:1]}.
- ITER, divide (32 cycles):
  - Form {t,R,Q}={HI,LO}<<1, where t is the shifted-out bit.
  - Adder computes R+~M+1.
  - If t|carry: HI<=sum, LO<={Q[31:1],1}.
  - Otherwise: HI<=R, LO<={Q[31:1],0}.
- Counter and exit: cnt increments each ITER cycle. Exit after cnt==31 to FIX_LO (signed) or DONE (unsigned).
- FIX_LO:
  - MULT with sA^sB: LO<=~LO+1 and save the carry.
  - DIV with sA^sB: LO<=~LO+1.
- FIX_HI:
  - MULT with sA^sB: HI<=~HI+saved carry.
  - DIV with sA: HI<=~HI+1 (remainder takes the dividend's sign).
- Fix states always take 1 cycle each, whether or not they write back. This gives fixed latency.
- Latency from E0 to done_out high: 32 cycles unsigned, 36 signed.
- Once in DONE, HI/LO stay stable until the next acceptance. DONE returns to IDLE unless start_in is high, in which case it re-accepts directly (back-to-back).
- start_in while busy is ignored: no state change, no operand latch.
- Divide by zero:
  - No trap; the op runs full length.
  - Unsigned result: LO=0xFFFFFFFF, HI=dividend.
  - Signed result: the same unsigned result, then sign fixes applied.
  - div0_out=1.
- Arithmetic wraps:
  - DIV 0x80000000/-1 gives LO=0x80000000, HI=0.
  - |0x80000000| stays 0x80000000 and is treated as unsigned.
- Reset mid-operation: immediate abort. HI/LO are cleared; no partial results are retained.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
  - the state enum
  - MDU_ITERS=32
  - latency constants 32 and 36
- One natural sub-module: mdu_adder_mux. It is the combinational selection of add_A/B/C from state, op and LO[0]/t. The FSM, counter and HI/LO registers stay in the top.

Test Plan:
1. MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done 32 cycles after E0; HI=0xFFFFFFFE, LO=0x00000001; busy high for 32 cycles.
2. MULT A=-3 B=7 -> done at 36; HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT A=0x80000000 B=0x80000000 -> HI=0x40000000, LO=0.
3. DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=100 B=7 -> LO=14, HI=2, div0=0.
4. DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=0x00000064, div0_out=1; the next accepted MULTU clears div0.
5. Start MULTU, pulse start_in with new operands at cycle 5, assert rst_in at cycle 10 -> second start ignored; after reset busy=0, HI=LO=0, state IDLE.
6. start_in held high across DONE -> second op accepted on the DONE edge with no IDLE cycle; done pulses exactly once per op.
